router_pkt_tx: RTL and testbench
================================

Name: router_pkt_tx

Overview:
Packet source that drives one router input port using the router's byte protocol:
- Header byte {len[5:0], dest[1:0]}, then `len` payload bytes, all sent with pkt_valid=1.
- Then one parity byte sent with pkt_valid=0. The parity byte is the XOR of the header and all payload bytes.

The host loads the payload into an internal buffer first, so the packet is sent with no bubbles. Transmission honours the router's busy signal. The block then samples the router's err flag and reports a per-packet status.

Parameters:
- MAX_LEN, 63, largest payload length accepted; buffer depth. Legal values 1..63.
- ERR_WAIT, 4, number of cycles after the parity byte is consumed during which err_in is sampled.

Ports:
- clk  in  1  clock; all logic on posedge.
- resetn  in  1  synchronous active-low reset.
- start  in  1  request a packet; sampled only in IDLE.
- dest  in  2  destination address, sampled with start.
- len  in  6  payload byte count, sampled with start.
- pay_data  in  8  payload byte from host.
- pay_valid  in  1  pay_data valid.
- pay_ready  out  1  block accepts a payload byte.
- busy  in  1  router busy; the current output byte is held while high.
- err_in  in  1  router parity error flag.
- data_out  out  8  byte to router.
- pkt_valid  out  1  packet_valid to router.
- tx_idle  out  1  block is in IDLE.
- cfg_err  out  1  1-cycle pulse: start rejected.
- tx_done  out  1  1-cycle pulse: packet complete.
- tx_status  out  1  valid with tx_done; 1 = router flagged a parity error.

Behaviour:

Reset (resetn=0 at posedge, in any state, including mid-packet):
- state=IDLE; counters and parity register = 0.
- data_out=0, pkt_valid=0, pay_ready=0, cfg_err=0, tx_done=0, tx_status=0, tx_idle=1.
- Buffer contents are don't-care.

All outputs come from registers or decode of registered state; no combinational path from busy, err_in or pay_valid to any output.

FSM states: IDLE, LOAD, HEADER, PAYLOAD, PARITY, ERRWAIT, DONE.

IDLE:
- tx_idle=1; data_out=0, pkt_valid=0.
- start=1 with dest==3 or len==0 or len>MAX_LEN → cfg_err pulses next cycle; stay in IDLE.
- start=1 otherwise → latch hdr={len,dest}, parity<=hdr, load cnt<=0, go to LOAD.
- start outside IDLE is ignored.

LOAD:
- pay_ready=1.
- Each cycle with pay_valid=1: buf[cnt]<=pay_data, parity<=parity^pay_data, cnt++.
- On the byte where cnt==len-1 → go to HEADER; pay_ready is 0 from the next cycle.
- pay_valid=0 → wait with no timeout.

HEADER:
- data_out=hdr, pkt_valid=1.
- Posedge with busy=0 → byte consumed; idx<=0; go to PAYLOAD.
- busy=1 → hold.

PAYLOAD:
- data_out=buf[idx], pkt_valid=1.
- Posedge with busy=0 → idx++; when idx==len-1 at that edge → go to PARITY.
- busy=1 → hold byte and idx.

PARITY:
- data_out=parity, pkt_valid=0.
- Posedge with busy=0 → consumed; load wcnt<=ERR_WAIT-1, go to ERRWAIT.
- busy=1 → hold.

ERRWAIT:
- data_out=0, pkt_valid=0.
- err_sticky<=err_sticky | err_in each cycle; wcnt decrements.
- When wcnt==0 → go to DONE.

DONE (one cycle):
- tx_done=1, tx_status=err_sticky.
- Clear err_sticky; go to IDLE.

Timing:
- No busy stalls and continuous pay_valid: pkt_valid is high for len+1 consecutive cycles, then the parity byte follows for exactly 1 cycle.
- Minimum back-to-back start-to-start spacing: 1 (start) + len (LOAD) + len+2 (HEADER/PAYLOAD/PARITY) + ERR_WAIT + 1 (DONE) cycles.

Parity arithmetic is an 8-bit XOR with no width growth.

Test Plan:
1. dest=1, len=3, payload 0x11,0x22,0x33, busy=0 → data_out sequence 0x0D,0x11,0x22,0x33 with pkt_valid=1,1,1,1, then 0x0D with pkt_valid=0; tx_done pulses with tx_status=0.
2. Same packet with busy=1 for 3 cycles while 0x22 is presented → 0x22 and pkt_valid=1 held for 4 cycles; no byte skipped or duplicated; parity byte still 0x0D.
3. start with dest=3, len=5; and separately start with len=0 → cfg_err 1-cycle pulse each time, pay_ready stays 0, tx_idle stays 1, pkt_valid never rises.
4. dest=2, len=63, payload 0x00..0x3E with pay_valid toggling every other cycle → 64 contiguous pkt_valid=1 bytes with header 0xFE; parity byte = 0xFE ^ XOR(0x00..0x3E) = 0xC1.
5. err_in pulsed 2 cycles after the parity byte is consumed → tx_done with tx_status=1. The next packet, with err_in=0, reports tx_status=0.
6. resetn=0 for 1 cycle while the 2nd payload byte is on data_out → next cycle data_out=0, pkt_valid=0, tx_idle=1; a new start sends a correct packet.

Source files
------------

// File: rtl/router_pkt_tx.sv
// Packet source for one router input port: buffers a host payload, then sends
// header, payload and XOR parity back-to-back under busy flow control.
module router_pkt_tx #(
    parameter int unsigned MAX_LEN  = 63,
    parameter int unsigned ERR_WAIT = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] dest,
    input  logic [5:0] len,
    input  logic [7:0] pay_data,
    input  logic       pay_valid,
    output logic       pay_ready,
    input  logic       busy,
    input  logic       err_in,
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       tx_idle,
    output logic       cfg_err,
    output logic       tx_done,
    output logic       tx_status
);

    localparam int unsigned WcntW = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;
    localparam logic [WcntW-1:0] WcntInit = WcntW'(ERR_WAIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StHeader,
        StPayload,
        StParity,
        StErrWait,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [7:0]       hdr_q, hdr_d;
    logic [7:0]       parity_q, parity_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [5:0]       idx_q, idx_d;
    logic [WcntW-1:0] wcnt_q, wcnt_d;
    logic             err_sticky_q, err_sticky_d;
    logic             cfg_err_q, cfg_err_d;

    logic [7:0] buf_mem_q [MAX_LEN];

    logic [5:0] pkt_len;
    logic       start_bad;

    assign pkt_len = hdr_q[7:2];

    always_comb begin
        start_bad = (dest == 2'd3) || (len == 6'd0) || (32'(len) > MAX_LEN);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start && !start_bad) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (pay_valid && (cnt_q == pkt_len - 6'd1)) begin
                    state_d = StHeader;
                end
            end
            StHeader: begin
                if (!busy) begin
                    state_d = StPayload;
                end
            end
            StPayload: begin
                if (!busy && (idx_q == pkt_len - 6'd1)) begin
                    state_d = StParity;
                end
            end
            StParity: begin
                if (!busy) begin
                    state_d = StErrWait;
                end
            end
            StErrWait: begin
                if (wcnt_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Datapath next-state: header/parity capture, counters, error sampling
    always_comb begin
        hdr_d        = hdr_q;
        parity_d     = parity_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        wcnt_d       = wcnt_q;
        err_sticky_d = err_sticky_q;
        cfg_err_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (start_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        hdr_d    = {len, dest};
                        parity_d = {len, dest};
                        cnt_d    = 6'd0;
                    end
                end
            end
            StLoad: begin
                if (pay_valid) begin
                    parity_d = parity_q ^ pay_data;
                    cnt_d    = cnt_q + 6'd1;
                end
            end
            StHeader: begin
                if (!busy) begin
                    idx_d = 6'd0;
                end
            end
            StPayload: begin
                if (!busy) begin
                    idx_d = idx_q + 6'd1;
                end
            end
            StParity: begin
                if (!busy) begin
                    wcnt_d = WcntInit;
                end
            end
            StErrWait: begin
                err_sticky_d = err_sticky_q | err_in;
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            StDone: begin
                err_sticky_d = 1'b0;
            end
            default: begin
                cfg_err_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hdr_q        <= 8'h00;
            parity_q     <= 8'h00;
            cnt_q        <= 6'd0;
            idx_q        <= 6'd0;
            wcnt_q       <= '0;
            err_sticky_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            hdr_q        <= hdr_d;
            parity_q     <= parity_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            wcnt_q       <= wcnt_d;
            err_sticky_q <= err_sticky_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    // Payload buffer carries no reset; its contents are only read after a full load
    always_ff @(posedge clk) begin
        if ((state_q == StLoad) && pay_valid) begin
            buf_mem_q[cnt_q] <= pay_data;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        data_out  = 8'h00;
        pkt_valid = 1'b0;
        pay_ready = 1'b0;
        tx_idle   = 1'b0;
        tx_done   = 1'b0;
        tx_status = 1'b0;
        case (state_q)
            StIdle: begin
                tx_idle = 1'b1;
            end
            StLoad: begin
                pay_ready = 1'b1;
            end
            StHeader: begin
                data_out  = hdr_q;
                pkt_valid = 1'b1;
            end
            StPayload: begin
                data_out  = buf_mem_q[idx_q];
                pkt_valid = 1'b1;
            end
            StParity: begin
                data_out = parity_q;
            end
            StDone: begin
                tx_done   = 1'b1;
                tx_status = err_sticky_q;
            end
            default: begin
                data_out = 8'h00;
            end
        endcase
    end

    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: hand-computed byte sequences, flow control,
// config rejection, error reporting and mid-packet reset.
module tb_router_pkt_tx;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [1:0] dest;
    logic [5:0] len;
    logic [7:0] pay_data;
    logic       pay_valid;
    logic       pay_ready;
    logic       busy;
    logic       err_in;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_idle;
    logic       cfg_err;
    logic       tx_done;
    logic       tx_status;

    int total = 0;
    int bad   = 0;

    logic [7:0] pay [64];

    router_pkt_tx #(
        .MAX_LEN (63),
        .ERR_WAIT(4)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .dest     (dest),
        .len      (len),
        .pay_data (pay_data),
        .pay_valid(pay_valid),
        .pay_ready(pay_ready),
        .busy     (busy),
        .err_in   (err_in),
        .data_out (data_out),
        .pkt_valid(pkt_valid),
        .tx_idle  (tx_idle),
        .cfg_err  (cfg_err),
        .tx_done  (tx_done),
        .tx_status(tx_status)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic v);
        chk8({tag, "_data"}, data_out, d);
        chk1({tag, "_valid"}, pkt_valid, v);
    endtask

    // Starts a packet from IDLE and feeds pay[0..l-1]; returns with the header on the bus
    task automatic load_pkt(input logic [1:0] d, input logic [5:0] l, input logic gap);
        start = 1'b1;
        dest  = d;
        len   = l;
        tick();
        start = 1'b0;
        chk1("load_ready", pay_ready, 1'b1);
        chk1("load_pktv", pkt_valid, 1'b0);
        chk1("load_idle", tx_idle, 1'b0);
        for (int i = 0; i < int'(l); i++) begin
            pay_valid = 1'b1;
            pay_data  = pay[i];
            tick();
            if (gap && (i != int'(l) - 1)) begin
                pay_valid = 1'b0;
                tick();
                chk1("load_gap_ready", pay_ready, 1'b1);
            end
        end
        pay_valid = 1'b0;
        pay_data  = 8'h00;
        chk1("load_end_ready", pay_ready, 1'b0);
    endtask

    // Called with the parity byte on the bus; walks ERRWAIT and DONE
    task automatic finish_pkt(input logic exp_status);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("errwait", 8'h00, 1'b0);
            chk1("errwait_done", tx_done, 1'b0);
        end
        tick();
        chk1("done_pulse", tx_done, 1'b1);
        chk1("done_status", tx_status, exp_status);
        tick();
        chk1("after_done", tx_done, 1'b0);
        chk1("after_idle", tx_idle, 1'b1);
    endtask

    initial begin
        resetn    = 1'b0;
        start     = 1'b0;
        dest      = 2'd0;
        len       = 6'd0;
        pay_data  = 8'h00;
        pay_valid = 1'b0;
        busy      = 1'b0;
        err_in    = 1'b0;
        tick();
        tick();
        chk1("rst_idle", tx_idle, 1'b1);
        chk_out("rst", 8'h00, 1'b0);
        chk1("rst_ready", pay_ready, 1'b0);
        chk1("rst_cfg", cfg_err, 1'b0);
        chk1("rst_done", tx_done, 1'b0);
        chk1("rst_status", tx_status, 1'b0);
        resetn = 1'b1;
        tick();

        // 1: dest=1 len=3, header 0x0D, parity 0x0D
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        load_pkt(2'd1, 6'd3, 1'b0);
        chk_out("t1_hdr", 8'h0D, 1'b1);
        tick(); chk_out("t1_p0", 8'h11, 1'b1);
        tick(); chk_out("t1_p1", 8'h22, 1'b1);
        tick(); chk_out("t1_p2", 8'h33, 1'b1);
        tick(); chk_out("t1_par", 8'h0D, 1'b0);
        finish_pkt(1'b0);

        // 2: busy held for 3 cycles on 0x22
        load_pkt(2'd1, 6'd3, 1'b0);
        chk_out("t2_hdr", 8'h0D, 1'b1);
        tick(); chk_out("t2_p0", 8'h11, 1'b1);
        tick(); chk_out("t2_p1", 8'h22, 1'b1);
        busy = 1'b1;
        tick(); chk_out("t2_hold1", 8'h22, 1'b1);
        tick(); chk_out("t2_hold2", 8'h22, 1'b1);
        tick(); chk_out("t2_hold3", 8'h22, 1'b1);
        busy = 1'b0;
        tick(); chk_out("t2_p2", 8'h33, 1'b1);
        tick(); chk_out("t2_par", 8'h0D, 1'b0);
        finish_pkt(1'b0);

        // 3: rejected starts
        start = 1'b1; dest = 2'd3; len = 6'd5;
        tick();
        start = 1'b0;
        chk1("t3a_cfg", cfg_err, 1'b1);
        chk1("t3a_idle", tx_idle, 1'b1);
        chk1("t3a_ready", pay_ready, 1'b0);
        chk1("t3a_pktv", pkt_valid, 1'b0);
        tick();
        chk1("t3a_cfg_clr", cfg_err, 1'b0);
        chk1("t3a_idle2", tx_idle, 1'b1);
        start = 1'b1; dest = 2'd0; len = 6'd0;
        tick();
        start = 1'b0;
        chk1("t3b_cfg", cfg_err, 1'b1);
        chk1("t3b_idle", tx_idle, 1'b1);
        chk1("t3b_ready", pay_ready, 1'b0);
        chk1("t3b_pktv", pkt_valid, 1'b0);
        tick();
        chk1("t3b_cfg_clr", cfg_err, 1'b0);
        chk1("t3b_pktv2", pkt_valid, 1'b0);

        // 4: len=63 with gapped load, header 0xFE, parity 0xC1
        for (int i = 0; i < 63; i++) pay[i] = 8'(i);
        load_pkt(2'd2, 6'd63, 1'b1);
        chk_out("t4_hdr", 8'hFE, 1'b1);
        for (int i = 0; i < 63; i++) begin
            tick();
            chk_out("t4_pay", 8'(i), 1'b1);
        end
        tick(); chk_out("t4_par", 8'hC1, 1'b0);
        finish_pkt(1'b0);

        // 5: err_in inside the sampling window, then a clean packet
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        load_pkt(2'd1, 6'd3, 1'b0);
        tick(); tick(); tick();
        tick(); chk_out("t5_par", 8'h0D, 1'b0);
        tick();
        tick();
        err_in = 1'b1;
        tick();
        err_in = 1'b0;
        chk1("t5_wait3", tx_done, 1'b0);
        tick();
        chk1("t5_wait4", tx_done, 1'b0);
        tick();
        chk1("t5_done", tx_done, 1'b1);
        chk1("t5_status", tx_status, 1'b1);
        tick();
        chk1("t5_idle", tx_idle, 1'b1);
        load_pkt(2'd1, 6'd3, 1'b0);
        tick(); tick(); tick();
        tick(); chk_out("t5b_par", 8'h0D, 1'b0);
        finish_pkt(1'b0);

        // 6: reset while the 2nd payload byte is on the bus
        load_pkt(2'd1, 6'd3, 1'b0);
        tick(); chk_out("t6_p0", 8'h11, 1'b1);
        tick(); chk_out("t6_p1", 8'h22, 1'b1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk_out("t6_rst", 8'h00, 1'b0);
        chk1("t6_idle", tx_idle, 1'b1);
        chk1("t6_ready", pay_ready, 1'b0);
        pay[0] = 8'hA5; pay[1] = 8'h5A;
        load_pkt(2'd0, 6'd2, 1'b0);
        chk_out("t6_hdr", 8'h08, 1'b1);
        tick(); chk_out("t6_q0", 8'hA5, 1'b1);
        tick(); chk_out("t6_q1", 8'h5A, 1'b1);
        tick(); chk_out("t6_par", 8'hF7, 1'b0);
        finish_pkt(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
